matrix_feeder: RTL and testbench
================================

Name: matrix_feeder

Overview:
- Transmit side of the a/b strobe/ack stream consumed by the systolic matrix multiplier.
- Holds one N×N A matrix and one N×N B matrix (N = 2**LOG_SIZE), loaded through a simple write port.
- On a start pulse, streams element pairs (a, b) one per accepted handshake, then signals done.
- Sits between the testbench/host loader and the multiplier's a, b, in_stb, in_ack inputs.

Parameters:
- LOG_SIZE, 1, log2 of matrix dimension; N = 2**LOG_SIZE, element count E = N*N.
- DATA_W, 32, element width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe for the matrix store.
- wr_sel  input  1  0 = write A, 1 = write B.
- wr_addr  input  2*LOG_SIZE  element index, row-major (row*N + col).
- wr_data  input  DATA_W  element value.
- start  input  1  single-cycle request to begin streaming.
- a  output  DATA_W  A element of the current beat.
- b  output  DATA_W  B element of the current beat.
- out_stb  output  1  a/b valid.
- out_ack  input  1  consumer accepts the beat (connects to multiplier in_ack).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset: state IDLE; a=0, b=0, out_stb=0, busy=0, done=0; index counter=0. Store contents are not cleared.
- Storage: two E×DATA_W register arrays. A write occurs when wr_en=1 and state=IDLE. Writes in any other state are ignored.
- FSM states:
  - IDLE: start=1 -> STREAM, with idx=0 and busy=1 on the next edge. out_stb stays 0 that cycle.
  - STREAM: out_stb=1, a=A[idx], b=B[idx]. Outputs are registered and presented the cycle after entry.
  - Transfer occurs on any edge where out_stb=1 and out_ack=1. On transfer, idx increments and the next pair loads.
  - Transfer with idx=E-1 -> FINISH (or PAD; see Optional Feature). out_stb drops on that edge.
  - FINISH: done=1 for exactly one cycle, busy=0, -> IDLE.
- Handshake rules:
  - While out_stb=1 and out_ack=0, a, b and out_stb hold stable with no change.
  - out_ack while out_stb=0 is ignored.
  - Sustained out_ack gives one beat per cycle, so E beats complete in E cycles after the first valid.
- Latency: start -> first out_stb = 1 cycle. Last transfer -> done = 1 cycle.
- start while busy or in FINISH is ignored. start in the same cycle as done (state FINISH) is ignored; a restart needs start while in IDLE.
- Simultaneous wr_en and start in IDLE: the write takes effect, and the stream (which begins next cycle) reads the updated value.
- rst mid-stream: next edge forces IDLE, out_stb=0, busy=0, with no done pulse. A partially sent stream is abandoned.
- Index wraps naturally at E; idx never exceeds E-1 in STREAM.

Optional Feature:
- Macro: MATRIX_FEEDER_ZERO_PAD_EN.
- Defined: after beat E-1 is accepted, the FSM enters PAD and emits N-1 additional beats with a=0, b=0, out_stb=1, under the same handshake rules. These beats flush the systolic chain. The last pad transfer -> FINISH. The total beat count is E+N-1.
- Undefined: no PAD state; exactly E beats are sent.

Test Plan:
- Load/stream, LOG_SIZE=1: write A={1,2,3,4}, B={5,6,7,8}, start with out_ack tied 1 -> beats (1,5),(2,6),(3,7),(4,8) on 4 consecutive cycles. done pulses 1 cycle after the 4th beat; busy is low the same cycle.
- Backpressure: hold out_ack=0 for 3 cycles on beat 2 -> a=2, b=6 stable for all 3 cycles. No skipped or duplicated beat; 4 transfers total.
- Ignored inputs: wr_en writing A[0]=9 during STREAM and a second start mid-stream -> stream unchanged and a single done. Next run emits A[0]=1.
- Reset mid-stream: rst after beat 2 -> next cycle out_stb=0, busy=0, no done. A new start streams from (1,5).
- Simultaneous write+start in IDLE: write B[0]=0xAA with start -> first beat (1,0xAA).
- With MATRIX_FEEDER_ZERO_PAD_EN defined: same load -> 4 data beats then 1 beat (0,0). done follows the 5th transfer.

Source files
------------

// File: rtl/matrix_feeder.sv
// Streams a stored N x N A/B matrix pair, one (a, b) element pair per strobe/ack beat.
// Optional build macro MATRIX_FEEDER_ZERO_PAD_EN appends N-1 zero beats to flush the systolic chain.
module matrix_feeder #(
  parameter int LOG_SIZE = 1,
  parameter int DATA_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [2*LOG_SIZE-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  start,
  output logic [DATA_W-1:0]     a,
  output logic [DATA_W-1:0]     b,
  output logic                  out_stb,
  input  logic                  out_ack,
  output logic                  busy,
  output logic                  done
);

  localparam int N  = 2 ** LOG_SIZE;
  localparam int E  = N * N;
  localparam int AW = 2 * LOG_SIZE;

`ifdef MATRIX_FEEDER_ZERO_PAD_EN
  localparam int PW       = (LOG_SIZE > 0) ? LOG_SIZE : 1;
  localparam int PAD_LAST = (N > 1) ? N - 2 : 0;

  typedef enum logic [1:0] {IDLE, STREAM, PAD, FINISH} state_t;
`else
  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;
`endif

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              stb_q, stb_d;
`ifdef MATRIX_FEEDER_ZERO_PAD_EN
  logic [PW-1:0]     pad_q, pad_d;
`endif

  logic [DATA_W-1:0] mem_a_q [E];
  logic [DATA_W-1:0] mem_b_q [E];

  logic              wr_fire;
  logic              xfer;
  logic              idx_last;
  logic [AW-1:0]     idx_inc;
  logic [DATA_W-1:0] a_first;
  logic [DATA_W-1:0] b_first;

  assign wr_fire  = wr_en && (state_q == IDLE);
  assign xfer     = stb_q && out_ack;
  assign idx_last = (idx_q == AW'(E - 1));
  assign idx_inc  = idx_q + 1'b1;

  // A write landing on element 0 in the start cycle must be seen by the first beat.
  assign a_first = (wr_fire && !wr_sel && wr_addr == '0) ? wr_data : mem_a_q[0];
  assign b_first = (wr_fire &&  wr_sel && wr_addr == '0) ? wr_data : mem_b_q[0];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wr_sel) begin
        mem_b_q[wr_addr] <= wr_data;
      end else begin
        mem_a_q[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      stb_q   <= 1'b0;
`ifdef MATRIX_FEEDER_ZERO_PAD_EN
      pad_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      stb_q   <= stb_d;
`ifdef MATRIX_FEEDER_ZERO_PAD_EN
      pad_q   <= pad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    stb_d   = stb_q;
`ifdef MATRIX_FEEDER_ZERO_PAD_EN
    pad_d   = pad_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          idx_d   = '0;
          stb_d   = 1'b1;
          a_d     = a_first;
          b_d     = b_first;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (idx_last) begin
            idx_d = '0;
            a_d   = '0;
            b_d   = '0;
`ifdef MATRIX_FEEDER_ZERO_PAD_EN
            pad_d = '0;
            if (N > 1) begin
              state_d = PAD;
              stb_d   = 1'b1;
            end else begin
              state_d = FINISH;
              stb_d   = 1'b0;
            end
`else
            state_d = FINISH;
            stb_d   = 1'b0;
`endif
          end else begin
            idx_d = idx_inc;
            a_d   = mem_a_q[idx_inc];
            b_d   = mem_b_q[idx_inc];
          end
        end
      end
`ifdef MATRIX_FEEDER_ZERO_PAD_EN
      PAD: begin
        if (xfer) begin
          if (pad_q == PW'(PAD_LAST)) begin
            state_d = FINISH;
            stb_d   = 1'b0;
            pad_d   = '0;
          end else begin
            pad_d = pad_q + 1'b1;
          end
        end
      end
`endif
      FINISH: begin
        state_d = IDLE;
        stb_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    a       = a_q;
    b       = b_q;
    out_stb = stb_q;
    busy    = (state_q != IDLE) && (state_q != FINISH);
    done    = (state_q == FINISH);
  end

endmodule

// File: tb/tb_matrix_feeder.sv
// Randomized bench for matrix_feeder: a behavioural store model predicts every streamed beat.
// Honours MATRIX_FEEDER_ZERO_PAD_EN when defined for the whole build.
module tb_matrix_feeder;
  localparam int LS = 1;
  localparam int DW = 32;
  localparam int N  = 2 ** LS;
  localparam int E  = N * N;
`ifdef MATRIX_FEEDER_ZERO_PAD_EN
  localparam int NPAD = N - 1;
`else
  localparam int NPAD = 0;
`endif
  localparam int TOTAL = E + NPAD;

  logic          clk = 1'b0;
  logic          rst, wr_en, wr_sel, start, out_ack;
  logic [2*LS-1:0] wr_addr;
  logic [DW-1:0] wr_data, a, b;
  logic          out_stb, busy, done;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] ma [E];
  logic [DW-1:0] mb [E];

  always #5 clk = ~clk;

  matrix_feeder #(.LOG_SIZE(LS), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .a(a), .b(b), .out_stb(out_stb),
    .out_ack(out_ack), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_elem(input bit sel, input int addr, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = (2*LS)'(addr); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (sel) mb[addr] = d; else ma[addr] = d;
  endtask

  // One complete stream; expected beats come from the model store at start time.
  task automatic run(input int ack_pct, input int stall_beat, input int stall_n,
                     input bit disturb, input bit start_at_done,
                     input bit sw_en, input bit sw_sel, input int sw_addr,
                     input logic [DW-1:0] sw_data);
    logic [DW-1:0] ea [$];
    logic [DW-1:0] eb [$];
    int k, cyc, stalls;
    bit ack;
    if (sw_en) begin
      wr_en = 1'b1; wr_sel = sw_sel; wr_addr = (2*LS)'(sw_addr); wr_data = sw_data;
      if (sw_sel) mb[sw_addr] = sw_data; else ma[sw_addr] = sw_data;
    end
    for (int i = 0; i < E; i++) begin ea.push_back(ma[i]); eb.push_back(mb[i]); end
    for (int i = 0; i < NPAD; i++) begin ea.push_back('0); eb.push_back('0); end
    start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    chk("stb_first", out_stb, 1);
    chk("busy_first", busy, 1);
    k = 0; cyc = 0; stalls = 0;
    while (k < TOTAL && cyc < 400) begin
      chk($sformatf("a[%0d]", k), a, ea[k]);
      chk($sformatf("b[%0d]", k), b, eb[k]);
      chk("stb_beat", out_stb, 1);
      chk("done_beat", done, 0);
      ack = ($urandom_range(99) < ack_pct);
      if (k == stall_beat && stalls < stall_n) begin ack = 1'b0; stalls++; end
      out_ack = ack;
      if (disturb) begin
        wr_en = $urandom_range(1); wr_sel = $urandom_range(1);
        wr_addr = (2*LS)'($urandom_range(E - 1)); wr_data = $urandom;
        start = $urandom_range(1);
      end
      tick();
      out_ack = 1'b0; wr_en = 1'b0; start = 1'b0;
      if (ack) k++;
      cyc++;
    end
    if (k < TOTAL) chk("beat_timeout", k, TOTAL);
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("stb_at_done", out_stb, 0);
    if (start_at_done) start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_after", done, 0);
    chk("busy_after", busy, 0);
    chk("stb_after", out_stb, 0);
    $display("stream done: %0d beats in %0d cycles, first (%0h,%0h)", k, cyc, ea[0], eb[0]);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; out_ack = 1'b0;
    tick(); tick();
    chk("rst_a", a, 0); chk("rst_b", b, 0); chk("rst_stb", out_stb, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    rst = 1'b0;

    // Ack with nothing valid must not start anything.
    out_ack = 1'b1;
    repeat (3) begin tick(); chk("idle_ack_stb", out_stb, 0); chk("idle_ack_busy", busy, 0); end
    out_ack = 1'b0;

    for (int i = 0; i < E; i++) begin
      write_elem(1'b0, i, DW'(i + 1));
      write_elem(1'b1, i, DW'(i + 5));
    end
    run(100, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
    run(100, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
    run(100, -1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, '0);
    run(100, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);

    // Abandon a stream with reset after two accepted beats.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rs_a", a, ma[i]); chk("rs_b", b, mb[i]);
      out_ack = 1'b1; tick(); out_ack = 1'b0;
    end
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rs_stb", out_stb, 0); chk("rs_busy", busy, 0); chk("rs_done", done, 0);
    tick();
    chk("rs_done2", done, 0); chk("rs_busy2", busy, 0);
    $display("stream abandoned by reset after 2 beats");
    run(100, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);

    run(100, -1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 32'h0000_00AA);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < E; i++) begin
        write_elem(1'b0, i, $urandom);
        write_elem(1'b1, i, $urandom);
      end
      run($urandom_range(100, 30), $urandom_range(TOTAL - 1), $urandom_range(3),
          1'($urandom_range(1)), 1'($urandom_range(1)),
          1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(E - 1), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
